fnd_calc_scan: RTL

FND_CALC_SCAN -- requirements
Module: fnd_calc_scan

---
 rtl/fnd_calc_scan.sv | 112 +++++++++++
 1 files changed

// File: rtl/fnd_calc_scan.sv
// fnd_calc_scan: add/subtract calculator with binary-to-BCD conversion driving a multiplexed 7-segment display
module fnd_calc_scan #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [WIDTH-1:0]  i_A,
  input  logic [WIDTH-1:0]  i_B,
  input  logic              i_mode,
  input  logic              i_start,
  output logic              o_busy,
  output logic [DIGITS-1:0] o_digit,
  output logic [7:0]        o_fndfont
);
  function automatic int ndig(input int v);
    int n;
    n = 0;
    for (int x = v; x > 0; x = x / 10) n++;
    return n;
  endfunction
  localparam int MW = WIDTH + 1;
  localparam int NB = ndig((1 << MW) - 1);
  localparam int ND = NB > DIGITS ? NB : DIGITS;
  localparam int CW = $clog2(MW + 1);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int LIM_P = 10 ** DIGITS - 1;
  localparam int LIM_N = 10 ** (DIGITS - 1) - 1;
  localparam logic [7:0] FONT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  function automatic logic [7:0] font_of(input logic [3:0] d);
    return d > 4'd9 ? 8'hFF : FONT[d];
  endfunction
  typedef enum logic [1:0] {IDLE, CALC, CONV, LOAD} state_t;
  state_t            state;
  logic [WIDTH-1:0]  a, b;
  logic              mode, sign, ovf;
  logic [MW-1:0]     mag, sh, res;
  logic [4*ND-1:0]   bcd, adj;
  logic [CW-1:0]     cnt;
  logic [7:0]        disp [DIGITS];
  logic [7:0]        nxt [DIGITS];
  logic [SW-1:0]     scnt;
  logic [IW-1:0]     idx, idx_n;
  logic              last;
  assign res = mode ? (a >= b ? MW'(a) - MW'(b) : MW'(b) - MW'(a)) : MW'(a) + MW'(b);
  assign ovf = 32'(mag) > (sign ? LIM_N : LIM_P);
  assign last = scnt == SW'(SCAN_DIV - 1);
  assign idx_n = last ? (idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < ND; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_comb begin
    nxt = disp;
    for (int i = 0; i < DIGITS; i++)
      nxt[i] = ovf ? 8'h86 :
               (sign && i == DIGITS - 1) ? 8'hBF :
               (i == 0 || |(bcd >> (4 * i))) ? font_of(bcd[4*i +: 4]) : 8'hFF;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      o_busy <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp[i] <= i == 0 ? 8'hC0 : 8'hFF;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          a <= i_A;
          b <= i_B;
          mode <= i_mode;
          state <= CALC;
          o_busy <= 1'b1;
        end
        CALC: begin
          mag <= res;
          sh <= res;
          sign <= mode && a < b;
          bcd <= '0;
          cnt <= '0;
          state <= CONV;
        end
        CONV: begin
          bcd <= {adj[4*ND-2:0], sh[MW-1]};
          sh <= sh << 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(MW - 1)) state <= LOAD;
        end
        default: begin
          disp <= nxt;
          state <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      scnt <= '0;
      idx <= '0;
      o_digit <= ~DIGITS'(1);
      o_fndfont <= 8'hC0;
    end else begin
      scnt <= last ? '0 : scnt + SW'(1);
      idx <= idx_n;
      o_digit <= ~(DIGITS'(1) << idx_n);
      o_fndfont <= disp[idx_n];
    end
  end
endmodule
